// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the fetch stage: icodes, status codes and
// the fetch-control state type.
package y86_pkg;

   localparam logic [3:0] I_HALT = 4'd0;
   localparam logic [3:0] I_NOP  = 4'd1;
   localparam logic [3:0] I_JXX  = 4'd7;
   localparam logic [3:0] I_CALL = 4'd8;
   localparam logic [3:0] I_RET  = 4'd9;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef enum logic [1:0] {
      FS_RUN      = 2'd0,
      FS_RET_WAIT = 2'd1,
      FS_HALTED   = 2'd2
   } fetch_state_e;

   // Memory faults outrank illegal encodings, which outrank a legal halt.
   function automatic logic [2:0] fetch_stat(input logic       imem_error,
                                             input logic       instr_valid,
                                             input logic [3:0] icode);
      if (imem_error)          return STAT_ADR;
      else if (!instr_valid)   return STAT_INS;
      else if (icode == I_HALT) return STAT_HLT;
      else                     return STAT_AOK;
   endfunction

endpackage

// File: rtl/pc_predict.sv
// Always-taken next-PC prediction: jumps and calls go to valC, everything
// else falls through to valP.
module pc_predict
   import y86_pkg::*;
(
   input  logic [3:0]  icode,
   input  logic [63:0] val_c,
   input  logic [63:0] val_p,
   output logic [63:0] pred_pc
);

   assign pred_pc = (icode == I_JXX || icode == I_CALL) ? val_c : val_p;

endmodule

// File: rtl/pipe_fetch_ctrl.sv
// Fetch-stage sequencer: owns the predicted PC, picks the fetch address from
// mispredict / ret / prediction, and handles stalls, ret bubbles and halts.
module pipe_fetch_ctrl
   import y86_pkg::*;
#(
   parameter logic [63:0] RESET_PC    = 64'h0,
   parameter int          RET_BUBBLES = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  f_icode,
   input  logic [3:0]  f_ifun,
   input  logic [63:0] f_valC,
   input  logic [63:0] f_valP,
   input  logic        f_instr_valid,
   input  logic        f_imem_error,
   input  logic        stall_f,
   input  logic        m_mispredict,
   input  logic [63:0] m_valA,
   input  logic        w_ret,
   input  logic [63:0] w_valM,
   output logic [63:0] pc,
   output logic        f_valid,
   output logic [2:0]  f_stat,
   output logic        halted,
   output logic        ret_wait,
   output logic        protocol_err
);

   localparam logic [2:0] RET_CNT_TARGET = 3'(RET_BUBBLES);
   localparam logic [2:0] RET_CNT_MAX    = 3'd7;

   fetch_state_e state_reg;
   logic [63:0]  pred_pc_reg;
   logic [63:0]  pred_pc_next;
   logic [63:0]  pc_sel;
   logic [2:0]   ret_cnt_reg;
   logic [2:0]   stat_cur;
   logic         protocol_err_reg;
   logic         redirect_ret;
   logic         active;
   logic         unused_ifun;

   // ifun only matters to decode; fetch control ignores it.
   assign unused_ifun = ^f_ifun;

   pc_predict u_pc_predict (
      .icode   (f_icode),
      .val_c   (f_valC),
      .val_p   (f_valP),
      .pred_pc (pred_pc_next)
   );

   assign redirect_ret = (state_reg == FS_RET_WAIT) && w_ret;

   always_comb begin
      pc_sel = pred_pc_reg;
      if (m_mispredict)      pc_sel = m_valA;
      else if (redirect_ret) pc_sel = w_valM;
   end

   assign pc           = rst_n ? pc_sel : RESET_PC;
   assign active       = (state_reg == FS_RUN) || m_mispredict || redirect_ret;
   assign f_valid      = active && !stall_f;
   assign stat_cur     = fetch_stat(f_imem_error, f_instr_valid, f_icode);
   assign f_stat       = stat_cur;
   // A mispredict proves the halting instruction was speculative, so fetch
   // is live again in that very cycle.
   assign halted       = (state_reg == FS_HALTED) && !m_mispredict;
   assign ret_wait     = (state_reg == FS_RET_WAIT);
   assign protocol_err = protocol_err_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= FS_RUN;
         pred_pc_reg      <= RESET_PC;
         ret_cnt_reg      <= '0;
         protocol_err_reg <= 1'b0;
      end else begin
         if (w_ret && !m_mispredict &&
             (state_reg != FS_RET_WAIT || ret_cnt_reg != RET_CNT_TARGET))
            protocol_err_reg <= 1'b1;

         if (f_valid) begin
            pred_pc_reg <= pred_pc_next;
            ret_cnt_reg <= '0;
            if (stat_cur != STAT_AOK)  state_reg <= FS_HALTED;
            else if (f_icode == I_RET) state_reg <= FS_RET_WAIT;
            else                       state_reg <= FS_RUN;
         end else if (m_mispredict) begin
            // Stalled redirect: remember the target so it is fetched once the
            // stall lifts.
            pred_pc_reg <= m_valA;
            ret_cnt_reg <= '0;
            state_reg   <= FS_RUN;
         end else if (state_reg == FS_RET_WAIT && !w_ret && !stall_f &&
                      ret_cnt_reg != RET_CNT_MAX) begin
            ret_cnt_reg <= ret_cnt_reg + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
// Bench for pipe_fetch_ctrl: directed vector table, async reset check, then
// randomized cycles against a behavioural model of the fetch sequencer.
module tb_pipe_fetch_ctrl;

   localparam logic [63:0] RPC = 64'h100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  f_icode;
   logic [3:0]  f_ifun;
   logic [63:0] f_valC;
   logic [63:0] f_valP;
   logic        f_instr_valid;
   logic        f_imem_error;
   logic        stall_f;
   logic        m_mispredict;
   logic [63:0] m_valA;
   logic        w_ret;
   logic [63:0] w_valM;
   logic [63:0] pc;
   logic        f_valid;
   logic [2:0]  f_stat;
   logic        halted;
   logic        ret_wait;
   logic        protocol_err;

   int n_tests = 0;
   int n_fail  = 0;

   pipe_fetch_ctrl #(.RESET_PC(RPC), .RET_BUBBLES(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .f_icode(f_icode), .f_ifun(f_ifun), .f_valC(f_valC), .f_valP(f_valP),
      .f_instr_valid(f_instr_valid), .f_imem_error(f_imem_error),
      .stall_f(stall_f), .m_mispredict(m_mispredict), .m_valA(m_valA),
      .w_ret(w_ret), .w_valM(w_valM),
      .pc(pc), .f_valid(f_valid), .f_stat(f_stat), .halted(halted),
      .ret_wait(ret_wait), .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  icode;
      logic [63:0] valc;
      logic [63:0] valp;
      logic        ivalid;
      logic        imerr;
      logic        stall;
      logic        mis;
      logic [63:0] vala;
      logic        wret;
      logic [63:0] valm;
      logic [63:0] e_pc;
      logic        e_valid;
      logic [2:0]  e_stat;
      logic        e_halt;
      logic        e_rw;
      logic        e_perr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [3:0] icode, logic [63:0] valc, logic [63:0] valp,
                               logic ivalid, logic imerr, logic stall, logic mis,
                               logic [63:0] vala, logic wret, logic [63:0] valm,
                               logic [63:0] e_pc, logic e_valid, logic [2:0] e_stat,
                               logic e_halt, logic e_rw, logic e_perr);
      vec_t v;
      v.icode = icode; v.valc = valc; v.valp = valp; v.ivalid = ivalid;
      v.imerr = imerr; v.stall = stall; v.mis = mis; v.vala = vala;
      v.wret = wret; v.valm = valm; v.e_pc = e_pc; v.e_valid = e_valid;
      v.e_stat = e_stat; v.e_halt = e_halt; v.e_rw = e_rw; v.e_perr = e_perr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] icode, input logic [63:0] valc, input logic [63:0] valp,
                        input logic ivalid, input logic imerr, input logic stall, input logic mis,
                        input logic [63:0] vala, input logic wret, input logic [63:0] valm);
      f_icode = icode; f_ifun = 4'(icode + 4'd3); f_valC = valc; f_valP = valp;
      f_instr_valid = ivalid; f_imem_error = imerr; stall_f = stall;
      m_mispredict = mis; m_valA = vala; w_ret = wret; w_valM = valm;
   endtask

   // Behavioural model: fetch is live unless halted or waiting for a ret,
   // and any redirect revives it.
   bit          md_halt, md_wait, md_perr;
   int          md_cnt;
   logic [63:0] md_pred;

   task automatic model_reset();
      md_halt = 0; md_wait = 0; md_perr = 0; md_cnt = 0; md_pred = RPC;
   endtask

   function automatic logic [2:0] ref_stat(logic imerr, logic ivalid, logic [3:0] icode);
      if (imerr) return 3'd3;
      if (!ivalid) return 3'd4;
      if (icode == 4'd0) return 3'd2;
      return 3'd1;
   endfunction

   task automatic model_check_step(input int cyc);
      logic [63:0] e_pc;
      logic [2:0]  e_stat;
      bit          fetching, e_valid;
      e_pc = m_mispredict ? m_valA : (md_wait && w_ret) ? w_valM : md_pred;
      fetching = (!md_halt && !md_wait) || m_mispredict || (md_wait && w_ret);
      e_valid = fetching && !stall_f;
      e_stat = ref_stat(f_imem_error, f_instr_valid, f_icode);
      chk($sformatf("rnd%0d pc", cyc), pc, e_pc);
      chk($sformatf("rnd%0d f_valid", cyc), 64'(f_valid), 64'(e_valid));
      chk($sformatf("rnd%0d f_stat", cyc), 64'(f_stat), 64'(e_stat));
      chk($sformatf("rnd%0d halted", cyc), 64'(halted), 64'(md_halt && !m_mispredict));
      chk($sformatf("rnd%0d ret_wait", cyc), 64'(ret_wait), 64'(md_wait));
      chk($sformatf("rnd%0d protocol_err", cyc), 64'(protocol_err), 64'(md_perr));
      if (w_ret && !m_mispredict && (!md_wait || md_cnt != 3)) md_perr = 1;
      if (e_valid) begin
         md_pred = (f_icode == 4'd7 || f_icode == 4'd8) ? f_valC : f_valP;
         md_halt = (e_stat != 3'd1);
         md_wait = !md_halt && (f_icode == 4'd9);
         md_cnt  = 0;
      end else if (m_mispredict) begin
         md_pred = m_valA; md_halt = 0; md_wait = 0; md_cnt = 0;
      end else if (md_wait && !w_ret && !stall_f) begin
         md_cnt = (md_cnt < 7) ? md_cnt + 1 : 7;
      end
   endtask

   initial begin
      // icode valC valP ivalid imerr stall mis valA wret valM | pc valid stat halt rw perr
      vecs.push_back(mk(1, 0, 'h101, 1, 0, 0, 0, 0, 0, 0,      'h100, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 'h102, 1, 0, 0, 0, 0, 0, 0,      'h101, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 'h103, 1, 0, 0, 0, 0, 0, 0,      'h102, 1, 1, 0, 0, 0));
      vecs.push_back(mk(7, 'h200, 'h10c, 1, 0, 0, 0, 0, 0, 0,  'h103, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 'h201, 1, 0, 0, 0, 0, 0, 0,      'h200, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 'h10a, 1, 0, 0, 1, 'h109, 0, 0,  'h109, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 'h10b, 1, 0, 0, 0, 0, 0, 0,      'h10a, 1, 1, 0, 0, 0));
      vecs.push_back(mk(9, 0, 'h10c, 1, 0, 0, 0, 0, 0, 0,      'h10b, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 'h10d, 1, 0, 0, 0, 0, 0, 0,      'h10c, 0, 1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 'h10d, 1, 0, 0, 0, 0, 0, 0,      'h10c, 0, 1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 'h10d, 1, 0, 0, 0, 0, 0, 0,      'h10c, 0, 1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 'h41, 1, 0, 0, 0, 0, 1, 'h40,    'h40, 1, 1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 'h42, 1, 0, 0, 0, 0, 0, 0,       'h41, 1, 1, 0, 0, 0));
      // ret with one stall cycle inside the bubble window
      vecs.push_back(mk(9, 0, 'h50, 1, 0, 0, 0, 0, 0, 0,       'h42, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 'h51, 1, 0, 0, 0, 0, 0, 0,       'h50, 0, 1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 'h51, 1, 0, 1, 0, 0, 0, 0,       'h50, 0, 1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 'h51, 1, 0, 0, 0, 0, 0, 0,       'h50, 0, 1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 'h51, 1, 0, 0, 0, 0, 0, 0,       'h50, 0, 1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 'h61, 1, 0, 0, 0, 0, 1, 'h60,    'h60, 1, 1, 0, 1, 0));
      // halt, idle, then wrong-path recovery
      vecs.push_back(mk(0, 0, 'h62, 1, 0, 0, 0, 0, 0, 0,       'h61, 1, 2, 0, 0, 0));
      vecs.push_back(mk(1, 0, 'h63, 1, 0, 0, 0, 0, 0, 0,       'h62, 0, 1, 1, 0, 0));
      vecs.push_back(mk(1, 0, 'h63, 1, 0, 0, 0, 0, 0, 0,       'h62, 0, 1, 1, 0, 0));
      vecs.push_back(mk(1, 0, 'h63, 1, 0, 0, 0, 0, 0, 0,       'h62, 0, 1, 1, 0, 0));
      vecs.push_back(mk(1, 0, 'h63, 1, 0, 0, 0, 0, 0, 0,       'h62, 0, 1, 1, 0, 0));
      vecs.push_back(mk(1, 0, 'h63, 1, 0, 0, 0, 0, 0, 0,       'h62, 0, 1, 1, 0, 0));
      vecs.push_back(mk(1, 0, 'h31, 1, 0, 0, 1, 'h30, 0, 0,    'h30, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 'h32, 1, 0, 0, 0, 0, 0, 0,       'h31, 1, 1, 0, 0, 0));
      // imem error and illegal instruction
      vecs.push_back(mk(1, 0, 'h33, 1, 1, 0, 0, 0, 0, 0,       'h32, 1, 3, 0, 0, 0));
      vecs.push_back(mk(1, 0, 'h34, 1, 0, 0, 0, 0, 0, 0,       'h33, 0, 1, 1, 0, 0));
      vecs.push_back(mk(1, 0, 'h71, 0, 0, 0, 1, 'h70, 0, 0,    'h70, 1, 4, 0, 0, 0));
      vecs.push_back(mk(1, 0, 'h72, 1, 0, 0, 0, 0, 0, 0,       'h71, 0, 1, 1, 0, 0));
      vecs.push_back(mk(1, 0, 'h81, 1, 0, 0, 1, 'h80, 0, 0,    'h80, 1, 1, 0, 0, 0));
      // early w_ret after only 2 bubbles
      vecs.push_back(mk(9, 0, 'h90, 1, 0, 0, 0, 0, 0, 0,       'h81, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 'h91, 1, 0, 0, 0, 0, 0, 0,       'h90, 0, 1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 'h91, 1, 0, 0, 0, 0, 0, 0,       'h90, 0, 1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 'ha1, 1, 0, 0, 0, 0, 1, 'ha0,    'ha0, 1, 1, 0, 1, 0));
      vecs.push_back(mk(1, 0, 'ha2, 1, 0, 0, 0, 0, 0, 0,       'ha1, 1, 1, 0, 0, 1));
      vecs.push_back(mk(1, 0, 'ha3, 1, 0, 0, 0, 0, 0, 0,       'ha2, 1, 1, 0, 0, 1));
      vecs.push_back(mk(9, 0, 'hb0, 1, 0, 0, 0, 0, 0, 0,       'ha3, 1, 1, 0, 0, 1));

      rst_n = 1'b0;
      drive(1, 0, 'h555, 1, 0, 0, 0, 'h777, 0, 'h888);
      @(negedge clk);
      #2;
      chk("reset pc", pc, RPC);
      chk("reset f_valid", 64'(f_valid), 64'd1);
      chk("reset halted", 64'(halted), 64'd0);
      chk("reset ret_wait", 64'(ret_wait), 64'd0);
      chk("reset protocol_err", 64'(protocol_err), 64'd0);
      stall_f = 1'b1;
      #1;
      chk("reset stalled f_valid", 64'(f_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].icode, vecs[i].valc, vecs[i].valp, vecs[i].ivalid, vecs[i].imerr,
               vecs[i].stall, vecs[i].mis, vecs[i].vala, vecs[i].wret, vecs[i].valm);
         #2;
         chk($sformatf("vec%0d pc", i), pc, vecs[i].e_pc);
         chk($sformatf("vec%0d f_valid", i), 64'(f_valid), 64'(vecs[i].e_valid));
         chk($sformatf("vec%0d f_stat", i), 64'(f_stat), 64'(vecs[i].e_stat));
         chk($sformatf("vec%0d halted", i), 64'(halted), 64'(vecs[i].e_halt));
         chk($sformatf("vec%0d ret_wait", i), 64'(ret_wait), 64'(vecs[i].e_rw));
         chk($sformatf("vec%0d protocol_err", i), 64'(protocol_err), 64'(vecs[i].e_perr));
         $display("[TB] vec %0d pc=%0h f_valid=%0d f_stat=%0d halted=%0d ret_wait=%0d perr=%0d",
                  i, pc, f_valid, f_stat, halted, ret_wait, protocol_err);
         @(negedge clk);
      end

      // Asynchronous reset between edges while waiting on a ret.
      drive(1, 0, 'hb1, 1, 0, 0, 0, 0, 0, 0);
      #2;
      chk("pre-areset ret_wait", 64'(ret_wait), 64'd1);
      chk("pre-areset pc", pc, 64'hb0);
      #2 rst_n = 1'b0;
      #1;
      chk("areset pc", pc, RPC);
      chk("areset ret_wait", 64'(ret_wait), 64'd0);
      chk("areset protocol_err", 64'(protocol_err), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      chk("post-areset pc", pc, RPC);
      @(negedge clk);

      for (int seg = 0; seg < 4; seg++) begin
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         model_reset();
         for (int c = 0; c < 150; c++) begin
            int r;
            logic [3:0] ic;
            r = int'($urandom_range(0, 19));
            if (r == 0)      ic = 4'd0;
            else if (r < 8)  ic = 4'd1;
            else if (r < 11) ic = 4'd7;
            else if (r < 13) ic = 4'd8;
            else if (r < 16) ic = 4'd9;
            else             ic = 4'($urandom_range(2, 15));
            drive(ic, {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, 29) != 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 4) == 0,
                  md_halt ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0),
                  {$urandom, $urandom},
                  md_wait ? (md_cnt >= 3 ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0))
                          : ($urandom_range(0, 29) == 0),
                  {$urandom, $urandom});
            #2;
            model_check_step(seg * 150 + c);
            @(negedge clk);
         end
         $display("[TB] random segment %0d done, %0d checks so far", seg, n_tests);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
